// File: rtl/irig_b_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : irig_b_encoder_param
//  Purpose  : Parametrised IRIG-B (B00x, DC-level) time-code encoder. Latches
//             BCD time/date and control bits on each PPS edge, derives
//             straight-binary seconds by shift-add, and emits the 100-bit
//             pulse-width frame a fixed delay after PPS.
//  Revision : 1.0  initial release
// ============================================================================
module irig_b_encoder_param #(
  parameter int CLK_HZ        = 50000000,
  parameter int PPS_DELAY_CYC = 16,
  parameter bit CF_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic        enable,
  input  logic        pps,
  input  logic [7:0]  sec_bcd,
  input  logic [7:0]  min_bcd,
  input  logic [7:0]  hour_bcd,
  input  logic [11:0] day_bcd,
  input  logic [7:0]  year_bcd,
  input  logic [17:0] cf_bits,
  output logic        out,
  output logic        frame_start,
  output logic [6:0]  bit_idx,
  output logic        busy,
  output logic        pps_err,
  output logic        pps_miss
);

  localparam int c_bit_cyc = CLK_HZ / 100;
  localparam int c_cyc_w   = $clog2(c_bit_cyc);
  localparam int c_dly_w   = $clog2(PPS_DELAY_CYC + 1);

  localparam logic [c_cyc_w-1:0] c_cyc_one  = c_cyc_w'(1);
  localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(c_bit_cyc - 1);
  localparam logic [c_cyc_w-1:0] c_w_mark   = c_cyc_w'(4 * c_bit_cyc / 5);
  localparam logic [c_cyc_w-1:0] c_w_one    = c_cyc_w'(c_bit_cyc / 2);
  localparam logic [c_cyc_w-1:0] c_w_zero   = c_cyc_w'(c_bit_cyc / 5);
  localparam logic [c_dly_w-1:0] c_dly_one  = c_dly_w'(1);
  localparam logic [c_dly_w-1:0] c_dly_hit  = c_dly_w'(PPS_DELAY_CYC - 1);
  localparam logic [6:0]         c_idx_one  = 7'd1;
  localparam logic [6:0]         c_last_bit = 7'd99;

  // Position markers: bit 0 (Pr) and every bit ending in 9.
  function automatic logic [99:0] f_marker_mask();
    logic [99:0] m;
    m    = '0;
    m[0] = 1'b1;
    for (int i = 9; i < 100; i += 10) m[i] = 1'b1;
    return m;
  endfunction
  localparam logic [99:0] c_marker = f_marker_mask();

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAPT = 3'd1,
    S_CALC = 3'd2,
    S_WAIT = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_pps_s1, r_pps_s2, r_pps_d, r_pps_edge;
  logic                 w_edge;
  logic [2:0]           r_step;
  logic [7:0]           r_sh_sec, r_sh_min, r_sh_hour, r_sh_year;
  logic [11:0]          r_sh_day;
  logic [17:0]          r_sh_cf, w_cf;
  logic [7:0]           r_h, r_m, r_s;
  logic [16:0]          r_acc;
  logic [99:0]          w_frame, r_frame;
  logic [c_cyc_w-1:0]   r_cyc, w_width;
  logic [c_dly_w-1:0]   r_dly_cnt;
  logic                 r_dly_act;
  logic                 w_unused;

  // Two-flop PPS synchroniser followed by a registered rising-edge detect
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_pps_s1   <= 1'b0;
      r_pps_s2   <= 1'b0;
      r_pps_d    <= 1'b0;
      r_pps_edge <= 1'b0;
    end else begin
      r_pps_s1   <= pps;
      r_pps_s2   <= r_pps_s1;
      r_pps_d    <= r_pps_s2;
      r_pps_edge <= r_pps_s2 & ~r_pps_d;
    end
  end

  // An edge seen while disabled is discarded.
  assign w_edge = r_pps_edge & enable;

  // Capture (step 1) then four shift-add steps building SBS; runs in the
  // background so it can overlap bit 99 of the previous frame.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_step    <= 3'd0;
      r_sh_sec  <= '0;
      r_sh_min  <= '0;
      r_sh_hour <= '0;
      r_sh_day  <= '0;
      r_sh_year <= '0;
      r_sh_cf   <= '0;
      r_h       <= '0;
      r_m       <= '0;
      r_s       <= '0;
      r_acc     <= '0;
    end else if (!enable) begin
      r_step <= 3'd0;
    end else if (w_edge) begin
      r_step <= 3'd1;
    end else begin
      case (r_step)
        3'd1: begin
          r_sh_sec  <= sec_bcd;
          r_sh_min  <= min_bcd;
          r_sh_hour <= hour_bcd;
          r_sh_day  <= day_bcd;
          r_sh_year <= year_bcd;
          r_sh_cf   <= cf_bits;
          r_step    <= 3'd2;
        end
        3'd2: begin
          // 10*tens = 8*tens + 2*tens
          r_h    <= {1'b0, r_sh_hour[7:4], 3'b000} + {3'b000, r_sh_hour[7:4], 1'b0} + {4'b0000, r_sh_hour[3:0]};
          r_m    <= {1'b0, r_sh_min[7:4], 3'b000}  + {3'b000, r_sh_min[7:4], 1'b0}  + {4'b0000, r_sh_min[3:0]};
          r_s    <= {1'b0, r_sh_sec[7:4], 3'b000}  + {3'b000, r_sh_sec[7:4], 1'b0}  + {4'b0000, r_sh_sec[3:0]};
          r_step <= 3'd3;
        end
        3'd3: begin
          // 3600 = 2048 + 1024 + 512 + 16, truncated to 17 bits
          r_acc  <= {r_h[5:0], 11'b0} + {r_h[6:0], 10'b0} + {r_h, 9'b0} + {5'b0, r_h, 4'b0};
          r_step <= 3'd4;
        end
        3'd4: begin
          // 60 = 32 + 16 + 8 + 4
          r_acc  <= r_acc + {4'b0, r_m, 5'b0} + {5'b0, r_m, 4'b0} + {6'b0, r_m, 3'b0} + {7'b0, r_m, 2'b0};
          r_step <= 3'd5;
        end
        3'd5: begin
          r_acc  <= r_acc + {9'b0, r_s};
          r_step <= 3'd0;
        end
        default: r_step <= 3'd0;
      endcase
    end
  end

  generate
    if (CF_EN) begin : g_cf_on
      assign w_cf = r_sh_cf;
    end else begin : g_cf_off
      assign w_cf = '0;
    end
  endgenerate

  // Upper BCD bits beyond the frame field widths are not transmitted.
  assign w_unused = ^{r_sh_day[11:10], r_sh_cf};

  // Map shadow fields onto frame bit positions (markers carry no data bit)
  always_comb begin
    w_frame        = '0;
    w_frame[4:1]   = r_sh_sec[3:0];
    w_frame[8:6]   = r_sh_sec[6:4];
    w_frame[13:10] = r_sh_min[3:0];
    w_frame[17:15] = r_sh_min[6:4];
    w_frame[23:20] = r_sh_hour[3:0];
    w_frame[26:25] = r_sh_hour[5:4];
    w_frame[33:30] = r_sh_day[3:0];
    w_frame[38:35] = r_sh_day[7:4];
    w_frame[41:40] = r_sh_day[9:8];
    w_frame[53:50] = r_sh_year[3:0];
    w_frame[58:55] = r_sh_year[7:4];
    w_frame[68:60] = w_cf[8:0];
    w_frame[78:70] = w_cf[17:9];
    w_frame[88:80] = r_acc[8:0];
    w_frame[97:90] = r_acc[16:9];
  end

  // High-time of the bit currently being sent
  always_comb begin
    if (c_marker[bit_idx])      w_width = c_w_mark;
    else if (r_frame[bit_idx])  w_width = c_w_one;
    else                        w_width = c_w_zero;
  end

  // Frame sequencer: PPS handling, start delay, bit/cycle counters, outputs
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state     <= S_IDLE;
      r_dly_cnt   <= '0;
      r_dly_act   <= 1'b0;
      r_cyc       <= '0;
      r_frame     <= '0;
      out         <= 1'b0;
      frame_start <= 1'b0;
      bit_idx     <= '0;
      busy        <= 1'b0;
      pps_err     <= 1'b0;
      pps_miss    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      pps_err     <= 1'b0;
      pps_miss    <= 1'b0;
      if (!enable) begin
        r_state   <= S_IDLE;
        r_dly_act <= 1'b0;
        r_dly_cnt <= '0;
        r_cyc     <= '0;
        out       <= 1'b0;
        busy      <= 1'b0;
        bit_idx   <= '0;
      end else begin
        if (r_dly_act) r_dly_cnt <= r_dly_cnt + c_dly_one;
        case (r_state)
          S_CAPT: r_state <= S_CALC;
          S_CALC: if (r_step == 3'd5) r_state <= S_WAIT;
          S_RUN: begin
            if (r_cyc == c_cyc_last) begin
              r_cyc <= '0;
              if (bit_idx == c_last_bit) begin
                out     <= 1'b0;
                busy    <= 1'b0;
                bit_idx <= '0;
                if (r_dly_act || w_edge) begin
                  r_state <= S_WAIT;
                end else begin
                  r_state  <= S_IDLE;
                  pps_miss <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + c_idx_one;
                out     <= 1'b1;
              end
            end else begin
              r_cyc <= r_cyc + c_cyc_one;
              out   <= (r_cyc + c_cyc_one) < w_width;
            end
          end
          default: ;
        endcase

        if (w_edge) begin
          // A new second restarts capture and the start delay; mid-frame
          // it also aborts the frame being sent.
          r_dly_act <= 1'b1;
          r_dly_cnt <= c_dly_one;
          if (r_state != S_RUN) begin
            r_state <= S_CAPT;
          end else if (bit_idx != c_last_bit) begin
            r_state <= S_CAPT;
            pps_err <= 1'b1;
            out     <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
            r_cyc   <= '0;
          end
        end else if (r_dly_act && (r_dly_cnt == c_dly_hit)) begin
          // Start of frame; truncates bit 99 if it is still running.
          r_dly_act   <= 1'b0;
          r_frame     <= w_frame;
          r_state     <= S_RUN;
          r_cyc       <= '0;
          bit_idx     <= '0;
          out         <= 1'b1;
          busy        <= 1'b1;
          frame_start <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irig_b_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irig_b_encoder_param
//  Purpose  : Self-checking bench for irig_b_encoder_param at CLK_HZ=10000
//             (100 cycles per bit), PPS delay 16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irig_b_encoder_param;

  localparam int CLK_HZ = 10000;
  localparam int DLY    = 16;

  logic        clk = 1'b0;
  logic        _rst = 1'b0;
  logic        enable = 1'b0;
  logic        pps = 1'b0;
  logic [7:0]  sec_bcd = '0, min_bcd = '0, hour_bcd = '0, year_bcd = '0;
  logic [11:0] day_bcd = '0;
  logic [17:0] cf_bits = '0;
  logic        out, frame_start, busy, pps_err, pps_miss;
  logic [6:0]  bit_idx;

  irig_b_encoder_param #(.CLK_HZ(CLK_HZ), .PPS_DELAY_CYC(DLY), .CF_EN(1'b1)) dut (
    .clk(clk), ._rst(_rst), .enable(enable), .pps(pps),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
    .day_bcd(day_bcd), .year_bcd(year_bcd), .cf_bits(cf_bits),
    .out(out), .frame_start(frame_start), .bit_idx(bit_idx), .busy(busy),
    .pps_err(pps_err), .pps_miss(pps_miss)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int err_cnt = 0, miss_cnt = 0;
  always @(negedge clk) begin
    if (pps_err)  err_cnt  <= err_cnt + 1;
    if (pps_miss) miss_cnt <= miss_cnt + 1;
  end

  // PPS pulses 4 cycles wide starting at the scheduled cycle numbers
  int   pps_times[$];
  logic pps_drv;
  initial begin
    forever begin
      @(negedge clk);
      pps_drv = 1'b0;
      foreach (pps_times[i])
        if (cyc_cnt >= pps_times[i] && cyc_cnt < pps_times[i] + 4) pps_drv = 1'b1;
      pps = pps_drv;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  sec, min, hour;
    logic [11:0] day;
    logic [7:0]  year;
    logic [17:0] cf;
    int          sbs;
  } vec_t;

  typedef struct {
    int    frame;
    string name;
    int    lo, len, exp;
  } fld_t;

  vec_t vecs[4];
  fld_t flds[$];
  int   w[100];

  task automatic apply(input vec_t v);
    sec_bcd = v.sec; min_bcd = v.min; hour_bcd = v.hour;
    day_bcd = v.day; year_bcd = v.year; cf_bits = v.cf;
  endtask

  function automatic bit is_marker(input int i);
    return (i == 0) || (i % 10 == 9);
  endfunction

  function automatic logic [99:0] build_exp(input vec_t v);
    logic [99:0] f;
    int h, m, s, sbs;
    h   = v.hour[7:4] * 10 + v.hour[3:0];
    m   = v.min[7:4] * 10 + v.min[3:0];
    s   = v.sec[7:4] * 10 + v.sec[3:0];
    sbs = (h * 3600 + m * 60 + s) % 131072;
    f = '0;
    f[4:1]   = v.sec[3:0];  f[8:6]   = v.sec[6:4];
    f[13:10] = v.min[3:0];  f[17:15] = v.min[6:4];
    f[23:20] = v.hour[3:0]; f[26:25] = v.hour[5:4];
    f[33:30] = v.day[3:0];  f[38:35] = v.day[7:4];  f[41:40] = v.day[9:8];
    f[53:50] = v.year[3:0]; f[58:55] = v.year[7:4];
    f[68:60] = v.cf[8:0];   f[78:70] = v.cf[17:9];
    f[88:80] = sbs[8:0];    f[97:90] = sbs[16:9];
    return f;
  endfunction

  function automatic int dec_field(input int lo, input int len);
    int val = 0;
    for (int k = 0; k < len; k++) if (w[lo + k] == 50) val |= (1 << k);
    return val;
  endfunction

  // Wait for frame_start, optionally load the next second's time, then
  // record high-time of each of the 100 bits.
  task automatic capture(input int id, input int exp_start, input int next_vec);
    int n = 0, idx_bad = 0, busy_bad = 0;
    while (!frame_start && n < 30000) begin @(negedge clk); n++; end
    check($sformatf("f%0d frame_start seen", id), frame_start, 1);
    if (!frame_start) return;
    check($sformatf("f%0d start cycle", id), cyc_cnt, exp_start);
    if (next_vec >= 0) apply(vecs[next_vec]);
    for (int i = 0; i < 100; i++) w[i] = 0;
    for (int i = 0; i < 10000; i++) begin
      if (out) w[i / 100]++;
      if (bit_idx != 7'(i / 100)) idx_bad++;
      if (!busy) busy_bad++;
      @(negedge clk);
    end
    check($sformatf("f%0d bit_idx sequence errors", id), idx_bad, 0);
    check($sformatf("f%0d busy low cycles", id), busy_bad, 0);
  endtask

  task automatic verify(input int id, input vec_t v);
    logic [99:0] f;
    int ew;
    f = build_exp(v);
    for (int i = 0; i < 100; i++) begin
      ew = is_marker(i) ? 80 : (f[i] ? 50 : 20);
      check($sformatf("f%0d bit%0d high cycles", id, i), w[i], ew);
    end
    check($sformatf("f%0d sbs", id), dec_field(80, 9) | (dec_field(90, 8) << 9), v.sbs);
    foreach (flds[k])
      if (flds[k].frame == id)
        check($sformatf("f%0d %s", id, flds[k].name), dec_field(flds[k].lo, flds[k].len), flds[k].exp);
  endtask

  int t0, n, e0, m0;

  initial begin
    vecs[0] = '{8'h56, 8'h34, 8'h12, 12'h123, 8'h24, 18'h0,     45296};
    vecs[1] = '{8'h57, 8'h34, 8'h12, 12'h123, 8'h24, 18'h0,     45297};
    vecs[2] = '{8'h58, 8'h34, 8'h12, 12'h123, 8'h24, 18'h0,     45298};
    vecs[3] = '{8'h59, 8'h59, 8'h23, 12'h366, 8'h99, 18'h3FFFF, 86399};
    flds.push_back('{0, "sbs lo",     80, 9, 'h0F0});
    flds.push_back('{0, "sbs hi",     90, 8, 'h58});
    flds.push_back('{0, "sec units",   1, 4, 6});
    flds.push_back('{0, "sec tens",    6, 3, 5});
    flds.push_back('{0, "min units",  10, 4, 4});
    flds.push_back('{0, "hour tens",  25, 2, 1});
    flds.push_back('{0, "day units",  30, 4, 3});
    flds.push_back('{0, "day tens",   35, 4, 2});
    flds.push_back('{0, "day hund",   40, 2, 1});
    flds.push_back('{0, "year tens",  55, 4, 2});
    flds.push_back('{3, "cf lo",      60, 9, 'h1FF});
    flds.push_back('{3, "cf hi",      70, 9, 'h1FF});
    flds.push_back('{3, "sbs lo",     80, 9, 'h17F});
    flds.push_back('{3, "sbs hi",     90, 8, 'hA8});
    flds.push_back('{3, "day hund",   40, 2, 3});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset out", out, 0);
    check("reset frame_start", frame_start, 0);
    check("reset bit_idx", bit_idx, 0);
    check("reset busy", busy, 0);
    check("reset pps_err", pps_err, 0);
    check("reset pps_miss", pps_miss, 0);
    _rst = 1'b1;
    enable = 1'b1;
    apply(vecs[0]);
    repeat (5) @(negedge clk);

    // Three contiguous seconds, then no PPS
    t0 = cyc_cnt + 2;
    pps_times.push_back(t0);
    pps_times.push_back(t0 + 10000);
    pps_times.push_back(t0 + 20000);
    capture(0, t0 + 19, 1);
    verify(0, vecs[0]);
    capture(1, t0 + 10019, 2);
    verify(1, vecs[1]);
    capture(2, t0 + 20019, -1);
    check("end pps_miss", pps_miss, 1);
    check("end busy", busy, 0);
    check("end out", out, 0);
    verify(2, vecs[2]);
    @(negedge clk);
    check("pps_miss one cycle", pps_miss, 0);
    check("contiguous pps_err count", err_cnt, 0);
    check("contiguous pps_miss count", miss_cnt, 1);

    // Early second PPS mid-frame
    apply(vecs[0]);
    t0 = cyc_cnt + 2;
    pps_times.push_back(t0);
    pps_times.push_back(t0 + 5000);
    n = 0;
    while (!frame_start && n < 200) begin @(negedge clk); n++; end
    check("early first start cycle", cyc_cnt, t0 + 19);
    n = 0;
    while (!pps_err && n < 6000) begin @(negedge clk); n++; end
    check("pps_err cycle", cyc_cnt, t0 + 5004);
    check("pps_err out", out, 0);
    check("pps_err busy", busy, 0);
    n = 0;
    while (!frame_start && n < 200) begin @(negedge clk); n++; end
    check("restart start cycle", cyc_cnt, t0 + 5019);

    // Enable dropped at bit 40 (a one bit), edge while disabled ignored
    n = 0;
    while (bit_idx != 7'd40 && n < 6000) begin @(negedge clk); n++; end
    check("reached bit 40", bit_idx, 40);
    enable = 1'b0;
    e0 = err_cnt;
    m0 = miss_cnt;
    @(negedge clk);
    check("disable out", out, 0);
    check("disable busy", busy, 0);
    pps_times.push_back(cyc_cnt + 2);
    repeat (12) @(negedge clk);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (frame_start || busy) n++;
      @(negedge clk);
    end
    check("ignored edge activity", n, 0);
    check("disable pps_err count", err_cnt, e0);
    check("disable pps_miss count", miss_cnt, m0);

    // Re-enable with all-ones CF and a wrap-heavy time
    apply(vecs[3]);
    t0 = cyc_cnt + 2;
    pps_times.push_back(t0);
    capture(3, t0 + 19, -1);
    check("f3 end pps_miss", pps_miss, 1);
    verify(3, vecs[3]);

    // Asynchronous reset during a marker's high time
    repeat (4) @(negedge clk);
    t0 = cyc_cnt + 2;
    pps_times.push_back(t0);
    n = 0;
    while (!frame_start && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("pre-reset out", out, 1);
    #2 _rst = 1'b0;
    #1;
    check("async reset out", out, 0);
    check("async reset busy", busy, 0);
    @(negedge clk);
    _rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irig_b_encoder_param.md
Name: irig_b_encoder_param

Overview:
- Parametrised IRIG-B (B00x, DC-level) time-code encoder.
- Captures BCD time-of-day, day-of-year, year and control-function bits on each PPS rising edge, and computes straight-binary seconds (SBS) sequentially without multiplier IPs.
- Emits the 100-bit pulse-width frame starting a programmable delay after PPS.
- Sits between the time-keeping core and the IRIG output driver/modulator. Adds PPS edge detection, timing-error reporting, clock-rate generality and frame status.

Parameters:
- CLK_HZ, 50000000, clk frequency. Must be a multiple of 100. BIT_CYC = CLK_HZ/100.
- PPS_DELAY_CYC, 16, cycles from detected PPS edge to frame start. Legal range 8 .. BIT_CYC-1.
- CF_EN, 1, 1 = cf_bits inserted into the frame; 0 = CF field forced to zero.

Ports:
- clk  in  1  system clock
- _rst  in  1  reset
- enable  in  1  encoder enable; level input
- pps  in  1  asynchronous PPS; rising edge marks the second
- sec_bcd  in  8  {tens[3:0], units[3:0]}
- min_bcd  in  8  {tens, units}
- hour_bcd  in  8  {tens, units}
- day_bcd  in  12  {hundreds, tens, units}
- year_bcd  in  8  {tens, units}
- cf_bits  in  18  control-function field
- out  out  1  DC-level IRIG-B
- frame_start  out  1  1-cycle pulse on the first cycle of bit 0 (Pr)
- bit_idx  out  7  current bit index 0..99
- busy  out  1  frame in progress
- pps_err  out  1  1-cycle pulse: PPS edge arrived while bit_idx < 99
- pps_miss  out  1  1-cycle pulse: bit 99 ended with no pending PPS

Behaviour:
- Reset _rst, asynchronous, active-low; clock clk.
  - All outputs are 0 in reset. FSM = IDLE; shadow and frame registers are cleared.
- PPS path: 2-flop synchroniser plus a registered rising-edge detect. E denotes the cycle the detect pulse is high.
- FSM states: IDLE, CAPT, CALC, WAIT, RUN.
  - IDLE: out=0, busy=0. Goes to CAPT at E.
  - CAPT (1 cycle): latch all BCD inputs and cf_bits into shadow registers.
  - CALC (4 cycles), shift-add:
    - h = 10*tens + units
    - m = 10*tens + units
    - s = 10*tens + units
    - sbs[16:0] = h*3600 + m*60 + s, modulo 2^17
    - BCD digits > 9 are not checked; they are used arithmetically as-is.
  - WAIT: out=0. Leaves when the delay counter reaches E+PPS_DELAY_CYC. At that cycle the shadow is copied to the 100-bit frame register, bit_idx=0, frame_start=1, busy=1, and the state goes to RUN.
  - RUN: the bit counter runs 0..BIT_CYC-1. bit_idx increments at each wrap.
- Pulse widths per bit; out=1 for the first W cycles of the bit, 0 for the rest:
  - marker: W = 4*BIT_CYC/5
  - one: W = BIT_CYC/2
  - zero: W = BIT_CYC/5
  - Marker positions: 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
- Frame map (index = bit number; unlisted non-marker bits are 0):
  - sec units 1-4, sec tens[2:0] 6-8
  - min units 10-13, min tens[2:0] 15-17
  - hour units 20-23, hour tens[1:0] 25-26
  - day units 30-33, tens 35-38, hundreds[1:0] 40-41
  - year units 50-53, year tens 55-58
  - cf[8:0] 60-68, cf[17:9] 70-78
  - sbs[8:0] 80-88, sbs[16:9] 90-97
  - The LSB of each field is at the lower index.
- PPS edge during RUN:
  - bit_idx < 99: pps_err pulse. The current frame is aborted, out is forced to 0, and the FSM goes to CAPT.
  - bit_idx == 99: normal. CAPT/CALC run in the background into the shadow registers while bit 99 continues.
  - New frame starts at E+PPS_DELAY_CYC. If bit 99 has not ended by then, it is truncated.
  - If bit 99 ends first, out stays 0 (WAIT) until E+PPS_DELAY_CYC.
- Bit 99 ends with no edge seen: pps_miss pulse; go to IDLE, out=0.
- enable=0 for any cycle: synchronous return to IDLE, out=0, busy=0, no error pulses. An edge coincident with enable=0 is ignored.
- Async reset mid-frame: out drops to 0 immediately.

Test Plan:
- CLK_HZ=10000 (BIT_CYC=100), PPS_DELAY_CYC=16; time 12:34:56, day 123, year 24, cf=0; single PPS at E -> frame_start at E+16. Required bit values:
  - bits 80-88 = 0x0F0 and bits 90-97 = 0x58 (SBS 45296).
  - bits 1-4 = 6, bits 6-8 = 5.
  - bits 30-33 = 3, bits 35-38 = 2, bits 40-41 = 1.
- Same config: out high for 80 cycles on bits 0/9/99, 50 cycles on a one bit, 20 cycles on a zero bit.
- PPS period exactly 10000 cycles, 3 seconds, time incrementing -> contiguous frames, no pps_err/pps_miss, each SBS correct (45297, 45298).
- Second PPS 5000 cycles after the first -> pps_err pulse, out low, new frame_start 16 cycles after the second edge.
- No second PPS -> after bit 99, pps_miss one cycle, busy=0, out=0.
- enable dropped at bit 40 -> out=0 next cycle, busy=0; re-enable plus PPS -> normal frame. CF_EN=1, cf=0x3FFFF -> bits 60-68 and 70-78 all one-width.
